// File: rtl/axil_mem_pkg.sv
// Shared constants for the AXI4-Lite delay memory model: response codes, FSM
// state encodings and the LFSR feedback mask.
package axil_mem_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef logic [1:0] rdState_t;
  localparam rdState_t R_IDLE = 2'd0;
  localparam rdState_t R_WAIT = 2'd1;
  localparam rdState_t R_RESP = 2'd2;

  typedef logic [1:0] wrState_t;
  localparam wrState_t W_IDLE = 2'd0;
  localparam wrState_t W_WAIT = 2'd1;
  localparam wrState_t W_RESP = 2'd2;

  // Taps 16,14,13,11 expressed as bit positions 15,13,12,10.
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

endpackage

// File: rtl/axil_lfsr16.sv
// Free-running 16-bit Fibonacci LFSR; advances every cycle, reloads seed on reset.
module axil_lfsr16 import axil_mem_pkg::*; #(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clock,
  input  logic        reset,
  output logic [15:0] lfsr
);

  // An all-zero state would lock up the register.
  localparam logic [15:0] SafeSeed = (SEED == 16'h0) ? 16'h1 : SEED;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      lfsr <= SafeSeed;
    end else begin
      lfsr <= {lfsr[14:0], ^(lfsr & LFSR_TAPS)};
    end
  end

endmodule

// File: rtl/axil_delay_sram.sv
// AXI4-Lite slave memory with independent read/write channels, byte strobes,
// SLVERR for out-of-range addresses and a fixed or LFSR-random response delay.
module axil_delay_sram import axil_mem_pkg::*; #(
  parameter int          ADDR_W         = 32,
  parameter int          DATA_W         = 32,
  parameter int          DEPTH_LOG2     = 10,
  parameter int          DELAY_MODE     = 0,
  parameter int          FIX_DELAY      = 2,
  parameter int          MAX_DELAY_LOG2 = 3,
  parameter logic [15:0] LFSR_SEED      = 16'hACE1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  ar_valid,
  output logic                  ar_ready,
  input  logic [ADDR_W-1:0]     ar_addr,
  output logic                  r_valid,
  input  logic                  r_ready,
  output logic [DATA_W-1:0]     r_data,
  output logic [1:0]            r_resp,
  input  logic                  aw_valid,
  output logic                  aw_ready,
  input  logic [ADDR_W-1:0]     aw_addr,
  input  logic                  w_valid,
  output logic                  w_ready,
  input  logic [DATA_W-1:0]     w_data,
  input  logic [DATA_W/8-1:0]   w_strb,
  output logic                  b_valid,
  input  logic                  b_ready,
  output logic [1:0]            b_resp
);

  localparam int         STRB_W   = DATA_W / 8;
  localparam int         OFF      = $clog2(STRB_W);
  localparam int         HI       = OFF + DEPTH_LOG2;
  localparam int         DEPTH    = 1 << DEPTH_LOG2;
  localparam bit         RandMode = (DELAY_MODE != 0);
  localparam logic [3:0] FixDelay = 4'(FIX_DELAY);

  logic [15:0] lfsr;

  axil_lfsr16 #(
    .SEED (LFSR_SEED)
  ) u_lfsr (
    .clock (clock),
    .reset (reset),
    .lfsr  (lfsr)
  );

  logic [3:0] rdDelay;
  logic [3:0] wrDelay;
  assign rdDelay = RandMode ? 4'(lfsr[MAX_DELAY_LOG2-1:0])   : FixDelay;
  assign wrDelay = RandMode ? 4'(lfsr[MAX_DELAY_LOG2+3:4]) : FixDelay;

  logic [DATA_W-1:0] mem [DEPTH];

  // ---------------- read channel ----------------
  rdState_t              rdState;
  logic [3:0]            rdCnt;
  logic                  arFire;
  logic                  arOor;
  logic [DEPTH_LOG2-1:0] arIdx;

  assign arIdx    = ar_addr[HI-1:OFF];
  assign arOor    = |(ar_addr >> HI);
  assign ar_ready = !reset && (rdState == R_IDLE) && (!RandMode || lfsr[15]);
  assign arFire   = ar_valid && ar_ready;
  assign r_valid  = (rdState == R_RESP);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rdState <= R_IDLE;
      rdCnt   <= 4'd0;
      r_data  <= '0;
      r_resp  <= RESP_OKAY;
    end else begin
      unique case (rdState)
        R_IDLE: begin
          if (arFire) begin
            // Registered read: a same-cycle write commit is not yet visible.
            r_data  <= arOor ? '0 : mem[arIdx];
            r_resp  <= arOor ? RESP_SLVERR : RESP_OKAY;
            rdCnt   <= rdDelay;
            rdState <= (rdDelay == 4'd0) ? R_RESP : R_WAIT;
          end
        end
        R_WAIT: begin
          rdCnt <= rdCnt - 4'd1;
          if (rdCnt == 4'd1) rdState <= R_RESP;
        end
        R_RESP: begin
          if (r_ready) rdState <= R_IDLE;
        end
        default: rdState <= R_IDLE;
      endcase
    end
  end

  // ---------------- write channel ----------------
  wrState_t              wrState;
  logic [3:0]            wrCnt;
  logic                  awHeld;
  logic                  wHeld;
  logic [ADDR_W-1:0]     awAddrQ;
  logic [DATA_W-1:0]     wDataQ;
  logic [STRB_W-1:0]     wStrbQ;
  logic                  wrGate;
  logic                  commit;
  logic                  wrOor;
  logic [DEPTH_LOG2-1:0] wrIdx;

  assign wrGate   = !RandMode || lfsr[14];
  assign aw_ready = !reset && (wrState == W_IDLE) && !awHeld && wrGate;
  assign w_ready  = !reset && (wrState == W_IDLE) && !wHeld && wrGate;
  assign commit   = (wrState == W_IDLE) && awHeld && wHeld;
  assign wrIdx    = awAddrQ[HI-1:OFF];
  assign wrOor    = |(awAddrQ >> HI);
  assign b_valid  = (wrState == W_RESP);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wrState <= W_IDLE;
      wrCnt   <= 4'd0;
      awHeld  <= 1'b0;
      wHeld   <= 1'b0;
      awAddrQ <= '0;
      wDataQ  <= '0;
      wStrbQ  <= '0;
      b_resp  <= RESP_OKAY;
    end else begin
      if (aw_valid && aw_ready) begin
        awHeld  <= 1'b1;
        awAddrQ <= aw_addr;
      end
      if (w_valid && w_ready) begin
        wHeld  <= 1'b1;
        wDataQ <= w_data;
        wStrbQ <= w_strb;
      end
      unique case (wrState)
        W_IDLE: begin
          if (commit) begin
            awHeld  <= 1'b0;
            wHeld   <= 1'b0;
            b_resp  <= wrOor ? RESP_SLVERR : RESP_OKAY;
            wrCnt   <= wrDelay;
            wrState <= (wrDelay == 4'd0) ? W_RESP : W_WAIT;
          end
        end
        W_WAIT: begin
          wrCnt <= wrCnt - 4'd1;
          if (wrCnt == 4'd1) wrState <= W_RESP;
        end
        W_RESP: begin
          if (b_ready) wrState <= W_IDLE;
        end
        default: wrState <= W_IDLE;
      endcase
    end
  end

  // Storage has no reset; commit is already low while reset is asserted.
  always_ff @(posedge clock) begin
    if (commit && !wrOor) begin
      for (int i = 0; i < STRB_W; i++) begin
        if (wStrbQ[i]) mem[wrIdx][8*i +: 8] <= wDataQ[8*i +: 8];
      end
    end
  end

  logic unusedBits;
  assign unusedBits = ^{ar_addr[OFF-1:0], awAddrQ[OFF-1:0], lfsr};

endmodule

// File: tb/tb_axil_delay_sram.sv
// Self-checking bench: a fixed-delay instance for directed timing cases and a
// random-delay instance driven by randomized traffic against a word-array model.
module tb_axil_delay_sram;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  // Index 0: fixed mode, FIX_DELAY=2. Index 1: random mode, delays 0..7.
  logic        arValid [2];
  logic        arReady [2];
  logic [31:0] arAddr  [2];
  logic        rValid  [2];
  logic        rReady  [2];
  logic [31:0] rData   [2];
  logic [1:0]  rResp   [2];
  logic        awValid [2];
  logic        awReady [2];
  logic [31:0] awAddr  [2];
  logic        wValid  [2];
  logic        wReady  [2];
  logic [31:0] wData   [2];
  logic [3:0]  wStrb   [2];
  logic        bValid  [2];
  logic        bReady  [2];
  logic [1:0]  bResp   [2];

  axil_delay_sram #(.DELAY_MODE(0), .FIX_DELAY(2)) dutFix (
    .clock(clock), .reset(reset),
    .ar_valid(arValid[0]), .ar_ready(arReady[0]), .ar_addr(arAddr[0]),
    .r_valid(rValid[0]), .r_ready(rReady[0]), .r_data(rData[0]), .r_resp(rResp[0]),
    .aw_valid(awValid[0]), .aw_ready(awReady[0]), .aw_addr(awAddr[0]),
    .w_valid(wValid[0]), .w_ready(wReady[0]), .w_data(wData[0]), .w_strb(wStrb[0]),
    .b_valid(bValid[0]), .b_ready(bReady[0]), .b_resp(bResp[0])
  );

  axil_delay_sram #(.DELAY_MODE(1), .MAX_DELAY_LOG2(3)) dutRnd (
    .clock(clock), .reset(reset),
    .ar_valid(arValid[1]), .ar_ready(arReady[1]), .ar_addr(arAddr[1]),
    .r_valid(rValid[1]), .r_ready(rReady[1]), .r_data(rData[1]), .r_resp(rResp[1]),
    .aw_valid(awValid[1]), .aw_ready(awReady[1]), .aw_addr(awAddr[1]),
    .w_valid(wValid[1]), .w_ready(wReady[1]), .w_data(wData[1]), .w_strb(wStrb[1]),
    .b_valid(bValid[1]), .b_ready(bReady[1]), .b_resp(bResp[1])
  );

  // Full write transaction; lat = cycles from the later of AW/W handshake to b_valid.
  task automatic axiWrite(input int d, input logic [31:0] addr, input logic [31:0] data,
                          input logic [3:0] strb, input int awDly, input int wDly,
                          input int bStall, output logic [1:0] resp, output int lat);
    int awCyc;
    int wCyc;
    awCyc = 0;
    wCyc  = 0;
    @(negedge clock);
    fork
      begin
        repeat (awDly) @(negedge clock);
        awValid[d] = 1'b1;
        awAddr[d]  = addr;
        for (int k = 0; k < 50 && !awReady[d]; k++) @(negedge clock);
        checks++;
        if (awReady[d] !== 1'b1) begin
          errors++;
          $display("FAIL aw_handshake dut=%0d addr=%h ready=%b want 1", d, addr, awReady[d]);
        end
        awCyc = cyc;
        @(posedge clock);
        #1 awValid[d] = 1'b0;
      end
      begin
        repeat (wDly) @(negedge clock);
        wValid[d] = 1'b1;
        wData[d]  = data;
        wStrb[d]  = strb;
        for (int k = 0; k < 50 && !wReady[d]; k++) @(negedge clock);
        checks++;
        if (wReady[d] !== 1'b1) begin
          errors++;
          $display("FAIL w_handshake dut=%0d addr=%h ready=%b want 1", d, addr, wReady[d]);
        end
        wCyc = cyc;
        @(posedge clock);
        #1 wValid[d] = 1'b0;
      end
    join
    for (int k = 0; k < 50; k++) begin
      @(negedge clock);
      if (bValid[d] === 1'b1) break;
    end
    checks++;
    if (bValid[d] !== 1'b1) begin
      errors++;
      $display("FAIL b_timeout dut=%0d addr=%h b_valid=%b want 1", d, addr, bValid[d]);
      resp = 2'bxx;
      lat  = -1;
      return;
    end
    lat  = cyc - ((awCyc > wCyc) ? awCyc : wCyc);
    resp = bResp[d];
    repeat (bStall) begin
      @(negedge clock);
      checks++;
      if (bValid[d] !== 1'b1 || bResp[d] !== resp) begin
        errors++;
        $display("FAIL b_stable dut=%0d valid=%b resp=%b want 1/%b", d, bValid[d], bResp[d], resp);
      end
    end
    bReady[d] = 1'b1;
    @(posedge clock);
    #1 bReady[d] = 1'b0;
    @(negedge clock);
    checks++;
    if (bValid[d] !== 1'b0) begin
      errors++;
      $display("FAIL b_duplicate dut=%0d b_valid=%b want 0", d, bValid[d]);
    end
  endtask

  // Full read transaction; lat = cycles from AR handshake to r_valid.
  task automatic axiRead(input int d, input logic [31:0] addr, input int arDly,
                         input int rStall, output logic [31:0] data, output logic [1:0] resp,
                         output int lat);
    int hsCyc;
    @(negedge clock);
    repeat (arDly) @(negedge clock);
    arValid[d] = 1'b1;
    arAddr[d]  = addr;
    for (int k = 0; k < 50 && !arReady[d]; k++) @(negedge clock);
    checks++;
    if (arReady[d] !== 1'b1) begin
      errors++;
      $display("FAIL ar_handshake dut=%0d addr=%h ready=%b want 1", d, addr, arReady[d]);
    end
    hsCyc = cyc;
    @(posedge clock);
    #1 arValid[d] = 1'b0;
    for (int k = 0; k < 50; k++) begin
      @(negedge clock);
      if (rValid[d] === 1'b1) break;
    end
    checks++;
    if (rValid[d] !== 1'b1) begin
      errors++;
      $display("FAIL r_timeout dut=%0d addr=%h r_valid=%b want 1", d, addr, rValid[d]);
      data = 'x;
      resp = 2'bxx;
      lat  = -1;
      return;
    end
    lat  = cyc - hsCyc;
    data = rData[d];
    resp = rResp[d];
    repeat (rStall) begin
      @(negedge clock);
      checks++;
      if (rValid[d] !== 1'b1 || rData[d] !== data || rResp[d] !== resp) begin
        errors++;
        $display("FAIL r_stable dut=%0d valid=%b data=%h resp=%b want 1/%h/%b",
                 d, rValid[d], rData[d], rResp[d], data, resp);
      end
    end
    rReady[d] = 1'b1;
    @(posedge clock);
    #1 rReady[d] = 1'b0;
    @(negedge clock);
    checks++;
    if (rValid[d] !== 1'b0) begin
      errors++;
      $display("FAIL r_duplicate dut=%0d r_valid=%b want 0", d, rValid[d]);
    end
  endtask

  function automatic logic [31:0] oorAddr();
    logic [31:0] a;
    a = $urandom;
    if (a[31:12] == 20'h0) a[12] = 1'b1;
    return a;
  endfunction

  task automatic test_reset();
    for (int d = 0; d < 2; d++) begin
      checks++;
      if ({rValid[d], bValid[d], rData[d], rResp[d], bResp[d]} !== 37'h0) begin
        errors++;
        $display("FAIL reset_outputs dut=%0d rv=%b bv=%b rdata=%h rresp=%b bresp=%b want 0",
                 d, rValid[d], bValid[d], rData[d], rResp[d], bResp[d]);
      end
      checks++;
      if ({arReady[d], awReady[d], wReady[d]} !== 3'b000) begin
        errors++;
        $display("FAIL reset_readys dut=%0d got %b%b%b want 000",
                 d, arReady[d], awReady[d], wReady[d]);
      end
    end
    reset = 1'b0;
    @(negedge clock);
    checks++;
    if ({arReady[0], awReady[0], wReady[0]} !== 3'b111) begin
      errors++;
      $display("FAIL idle_readys got %b%b%b want 111", arReady[0], awReady[0], wReady[0]);
    end
  endtask

  task automatic test_fixed_rw();
    logic [1:0]  resp;
    logic [31:0] data;
    int          lat;
    axiWrite(0, 32'h10, 32'hDEADBEEF, 4'hF, 0, 0, 0, resp, lat);
    checks++;
    if (resp !== 2'b00 || lat != 4) begin
      errors++;
      $display("FAIL fixed_write resp=%b lat=%0d want 00/4", resp, lat);
    end
    axiRead(0, 32'h10, 0, 0, data, resp, lat);
    checks++;
    if (data !== 32'hDEADBEEF || resp !== 2'b00) begin
      errors++;
      $display("FAIL fixed_read data=%h resp=%b want deadbeef/00", data, resp);
    end
    checks++;
    if (lat != 3) begin
      errors++;
      $display("FAIL fixed_read_latency got %0d want 3", lat);
    end
  endtask

  task automatic test_strobes();
    logic [1:0]  resp;
    logic [31:0] data;
    int          lat;
    axiWrite(0, 32'h20, 32'h11223344, 4'hF, 0, 0, 0, resp, lat);
    axiWrite(0, 32'h20, 32'hAABBCCDD, 4'b0101, 1, 0, 0, resp, lat);
    axiRead(0, 32'h22, 0, 1, data, resp, lat);
    checks++;
    if (data !== 32'h11BB33DD || resp !== 2'b00) begin
      errors++;
      $display("FAIL strobe_merge data=%h resp=%b want 11bb33dd/00", data, resp);
    end
    axiWrite(0, 32'h20, 32'hFFFFFFFF, 4'h0, 0, 2, 0, resp, lat);
    checks++;
    if (resp !== 2'b00) begin
      errors++;
      $display("FAIL strobe_zero_resp got %b want 00", resp);
    end
    axiRead(0, 32'h20, 0, 0, data, resp, lat);
    checks++;
    if (data !== 32'h11BB33DD) begin
      errors++;
      $display("FAIL strobe_zero_data got %h want 11bb33dd", data);
    end
  endtask

  task automatic test_w_before_aw();
    int          c0;
    logic [1:0]  resp;
    logic [31:0] data;
    int          lat;
    @(negedge clock);
    c0 = cyc;
    wValid[0] = 1'b1;
    wData[0]  = 32'h0BADCAFE;
    wStrb[0]  = 4'hF;
    @(negedge clock);
    checks++;
    if (wReady[0] !== 1'b0) begin
      errors++;
      $display("FAIL w_ready_drop got %b want 0", wReady[0]);
    end
    repeat (2) @(negedge clock);
    awValid[0] = 1'b1;
    awAddr[0]  = 32'h50;
    checks++;
    if (awReady[0] !== 1'b1) begin
      errors++;
      $display("FAIL aw_ready_late got %b want 1", awReady[0]);
    end
    @(posedge clock);
    #1;
    awValid[0] = 1'b0;
    wValid[0]  = 1'b0;
    // b_valid expected at c0+3 (AW) + 2 + FIX_DELAY(2).
    while (cyc < c0 + 7) begin
      @(negedge clock);
      checks++;
      if (bValid[0] !== (cyc >= c0 + 7)) begin
        errors++;
        $display("FAIL b_timing cyc=%0d b_valid=%b want %b", cyc - c0, bValid[0], cyc >= c0 + 7);
      end
    end
    repeat (4) begin
      @(negedge clock);
      checks++;
      if (bValid[0] !== 1'b1 || bResp[0] !== 2'b00) begin
        errors++;
        $display("FAIL b_hold valid=%b resp=%b want 1/00", bValid[0], bResp[0]);
      end
    end
    bReady[0] = 1'b1;
    @(posedge clock);
    #1 bReady[0] = 1'b0;
    repeat (3) begin
      @(negedge clock);
      checks++;
      if (bValid[0] !== 1'b0) begin
        errors++;
        $display("FAIL b_single got b_valid=%b want 0", bValid[0]);
      end
    end
    axiRead(0, 32'h50, 0, 0, data, resp, lat);
    checks++;
    if (data !== 32'h0BADCAFE) begin
      errors++;
      $display("FAIL w_first_data got %h want 0badcafe", data);
    end
  endtask

  task automatic test_out_of_range();
    logic [1:0]  resp;
    logic [31:0] data;
    int          lat;
    axiWrite(0, 32'h0, 32'h5A5A1234, 4'hF, 0, 0, 0, resp, lat);
    axiWrite(0, 32'hFFC, 32'h7777AAAA, 4'hF, 0, 0, 0, resp, lat);
    axiRead(0, 32'h1000, 0, 0, data, resp, lat);
    checks++;
    if (resp !== 2'b10 || data !== 32'h0) begin
      errors++;
      $display("FAIL oor_read resp=%b data=%h want 10/0", resp, data);
    end
    axiWrite(0, 32'h1000, 32'hFFFFFFFF, 4'hF, 0, 0, 0, resp, lat);
    checks++;
    if (resp !== 2'b10) begin
      errors++;
      $display("FAIL oor_write_resp got %b want 10", resp);
    end
    axiRead(0, 32'h0, 0, 0, data, resp, lat);
    checks++;
    if (data !== 32'h5A5A1234 || resp !== 2'b00) begin
      errors++;
      $display("FAIL oor_write_suppressed data=%h resp=%b want 5a5a1234/00", data, resp);
    end
    axiRead(0, 32'hFFF, 0, 0, data, resp, lat);
    checks++;
    if (data !== 32'h7777AAAA || resp !== 2'b00) begin
      errors++;
      $display("FAIL top_word data=%h resp=%b want 7777aaaa/00", data, resp);
    end
    axiRead(0, 32'h8000_0010, 0, 0, data, resp, lat);
    checks++;
    if (resp !== 2'b10 || data !== 32'h0) begin
      errors++;
      $display("FAIL oor_msb resp=%b data=%h want 10/0", resp, data);
    end
  endtask

  task automatic test_collision();
    logic [1:0]  resp;
    logic [1:0]  rresp;
    logic [31:0] data;
    int          lat;
    int          rlat;
    axiWrite(0, 32'h30, 32'h00000001, 4'hF, 0, 0, 0, resp, lat);
    // Both write handshakes in cycle S, commit in S+1, AR handshake in S+1.
    fork
      axiWrite(0, 32'h30, 32'h00000002, 4'hF, 0, 0, 0, resp, lat);
      axiRead(0, 32'h30, 1, 0, data, rresp, rlat);
    join
    checks++;
    if (data !== 32'h1) begin
      errors++;
      $display("FAIL collision_old got %h want 00000001", data);
    end
    axiRead(0, 32'h30, 0, 0, data, rresp, rlat);
    checks++;
    if (data !== 32'h2) begin
      errors++;
      $display("FAIL collision_new got %h want 00000002", data);
    end
  endtask

  task automatic test_reset_mid();
    logic [1:0]  resp;
    logic [31:0] data;
    int          lat;
    axiWrite(0, 32'h40, 32'hCAFEF00D, 4'hF, 0, 0, 0, resp, lat);
    for (int pass = 0; pass < 2; pass++) begin
      @(negedge clock);
      arValid[0] = 1'b1;
      arAddr[0]  = 32'h40;
      @(posedge clock);
      #1 arValid[0] = 1'b0;
      // pass 0: reset during the wait; pass 1: reset while r_valid is high.
      repeat (pass == 0 ? 1 : 3) @(negedge clock);
      if (pass == 1) begin
        checks++;
        if (rValid[0] !== 1'b1) begin
          errors++;
          $display("FAIL pre_reset_valid got %b want 1", rValid[0]);
        end
      end
      reset = 1'b1;
      #1;
      checks++;
      if (rValid[0] !== 1'b0 || rData[0] !== 32'h0 || arReady[0] !== 1'b0) begin
        errors++;
        $display("FAIL reset_async pass=%0d rv=%b rdata=%h ar_ready=%b want 0/0/0",
                 pass, rValid[0], rData[0], arReady[0]);
      end
      repeat (2) @(negedge clock);
      reset = 1'b0;
      repeat (8) begin
        @(negedge clock);
        checks++;
        if (rValid[0] !== 1'b0) begin
          errors++;
          $display("FAIL reset_dropped pass=%0d r_valid=%b want 0", pass, rValid[0]);
        end
      end
    end
    axiRead(0, 32'h40, 0, 0, data, resp, lat);
    checks++;
    if (data !== 32'hCAFEF00D || resp !== 2'b00 || lat != 3) begin
      errors++;
      $display("FAIL post_reset_read data=%h resp=%b lat=%0d want cafef00d/00/3", data, resp, lat);
    end
  endtask

  task automatic test_random();
    logic [31:0] model [16];
    logic [31:0] waddr;
    logic [31:0] raddr;
    logic [31:0] wdata;
    logic [31:0] expD;
    logic [31:0] got;
    logic [3:0]  strb;
    logic [1:0]  wresp;
    logic [1:0]  rresp;
    int          wlat;
    int          rlat;
    int          wi;
    int          ri;
    int          kind;
    bit          wOor;
    bit          rOor;
    for (int i = 0; i < 16; i++) begin
      model[i] = $urandom;
      axiWrite(1, 32'(i * 4), model[i], 4'hF, 0, 0, 0, wresp, wlat);
      checks++;
      if (wresp !== 2'b00) begin
        errors++;
        $display("FAIL rnd_init word=%0d resp=%b want 00", i, wresp);
      end
    end
    for (int n = 0; n < 1000; n++) begin
      kind  = int'($urandom_range(0, 2));
      wi    = int'($urandom_range(0, 15));
      ri    = int'($urandom_range(0, 15));
      if (kind == 2 && ri == wi) ri = (wi + 1) % 16;
      wOor  = ($urandom_range(0, 7) == 0);
      rOor  = ($urandom_range(0, 7) == 0);
      waddr = wOor ? oorAddr() : (32'(wi * 4) | 32'($urandom_range(0, 3)));
      raddr = rOor ? oorAddr() : (32'(ri * 4) | 32'($urandom_range(0, 3)));
      wdata = $urandom;
      strb  = 4'($urandom_range(0, 15));
      expD  = model[wi];
      for (int b = 0; b < 4; b++) if (strb[b]) expD[8*b +: 8] = wdata[8*b +: 8];
      if (kind == 0) begin
        axiWrite(1, waddr, wdata, strb, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                 int'($urandom_range(0, 3)), wresp, wlat);
      end else if (kind == 1) begin
        axiRead(1, raddr, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), got, rresp, rlat);
      end else begin
        fork
          axiWrite(1, waddr, wdata, strb, int'($urandom_range(0, 3)),
                   int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), wresp, wlat);
          axiRead(1, raddr, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                  got, rresp, rlat);
        join
      end
      if (kind != 1) begin
        checks++;
        if (wresp !== (wOor ? 2'b10 : 2'b00)) begin
          errors++;
          $display("FAIL rnd_bresp n=%0d addr=%h got %b want %b", n, waddr, wresp, wOor ? 2'b10 : 2'b00);
        end
        checks++;
        if (wlat < 2 || wlat > 9) begin
          errors++;
          $display("FAIL rnd_wlat n=%0d got %0d want 2..9", n, wlat);
        end
        if (!wOor) model[wi] = expD;
      end
      if (kind != 0) begin
        checks++;
        if (rresp !== (rOor ? 2'b10 : 2'b00) || got !== (rOor ? 32'h0 : model[ri])) begin
          errors++;
          $display("FAIL rnd_read n=%0d addr=%h got %h/%b want %h/%b", n, raddr, got, rresp,
                   rOor ? 32'h0 : model[ri], rOor ? 2'b10 : 2'b00);
        end
        checks++;
        if (rlat < 1 || rlat > 8) begin
          errors++;
          $display("FAIL rnd_rlat n=%0d got %0d want 1..8", n, rlat);
        end
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    for (int d = 0; d < 2; d++) begin
      arValid[d] = 1'b0; arAddr[d] = '0; rReady[d] = 1'b0;
      awValid[d] = 1'b0; awAddr[d] = '0; wValid[d] = 1'b0;
      wData[d]   = '0;   wStrb[d]  = '0; bReady[d] = 1'b0;
    end
    repeat (2) @(negedge clock);
    test_reset();
    test_fixed_rw();
    test_strobes();
    test_w_before_aw();
    test_out_of_range();
    test_collision();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #800000;
    $display("FAIL watchdog cyc=%0d want completion", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/axil_delay_sram.md
Name: axil_delay_sram

Overview:
- Parametrised AXI4-Lite slave memory model with independent read and write channels and a configurable response delay, either fixed or LFSR-random.
- Replaces the single-channel random-delay memory stub in the core testbench. Used behind the LSU/IFU arbiter to stress handshake timing.
- Adds over the previous generation: real backing storage, byte strobes, an error response for out-of-range addresses, independent AW/W arrival, and a selectable delay mode.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width; must be 32 or 64.
- DEPTH_LOG2, 10, log2 of the number of words.
- DELAY_MODE, 0, 0 = fixed delay, 1 = LFSR-random delay plus random ready gating.
- FIX_DELAY, 2, delay in cycles when DELAY_MODE = 0; range 0..15.
- MAX_DELAY_LOG2, 3, random delay is drawn from 0..2^MAX_DELAY_LOG2-1; range 1..4.
- LFSR_SEED, 16'hACE1, LFSR reset value; a seed of 0 is replaced by 1.

Ports:
- clock  in  1  single clock
- reset  in  1  asynchronous, active-high
- ar_valid in 1, ar_ready out 1, ar_addr in ADDR_W: read address channel
- r_valid out 1, r_ready in 1, r_data out DATA_W, r_resp out 2: read data channel
- aw_valid in 1, aw_ready out 1, aw_addr in ADDR_W: write address channel
- w_valid in 1, w_ready out 1, w_data in DATA_W, w_strb in DATA_W/8: write data channel
- b_valid out 1, b_ready in 1, b_resp out 2: write response channel

Behaviour:
- Reset: asserting reset immediately forces both FSMs to IDLE and the LFSR to seed.
  - r_valid, b_valid, r_data and both resp outputs are 0.
  - All readys are 0 while reset is high.
  - Storage is not reset.
  - A transaction in flight is dropped and no response is issued.
- Addressing:
  - OFF = log2(DATA_W/8).
  - Word index = addr[OFF+DEPTH_LOG2-1:OFF]; low OFF bits are ignored.
  - Any nonzero bit at or above OFF+DEPTH_LOG2 marks the address out of range: resp = SLVERR (2'b10), read data 0, write suppressed.
  - In-range accesses return OKAY (2'b00).
- LFSR: 16-bit Fibonacci, taps 16,14,13,11, advances every cycle including stalls.
  - Read delay = lfsr[MAX_DELAY_LOG2-1:0].
  - Write delay = lfsr[MAX_DELAY_LOG2+3:4].
  - Each delay is sampled at the handshake that starts its countdown.
- Read FSM states: R_IDLE, R_WAIT, R_RESP.
  - In R_IDLE, ar_ready = 1; in random mode it is also gated by lfsr[15].
  - ar_valid & ar_ready: array is read and r_data/r_resp are registered that cycle; delay counter is loaded.
  - If the delay is 0, go to R_RESP; otherwise go to R_WAIT.
  - R_WAIT: counter decrements each cycle and moves to R_RESP when it reaches 1 → 0.
  - Latency from AR handshake to r_valid = delay + 1 cycles.
  - R_RESP: r_valid = 1 with r_data/r_resp stable until r_ready; then R_IDLE. No new AR is accepted in the same cycle.
- Write FSM states: W_IDLE, W_WAIT, W_RESP.
  - In W_IDLE, aw_ready = !aw_held and w_ready = !w_held; in random mode both are also gated by lfsr[14].
  - AW and W are captured independently, in either order or in the same cycle.
  - Commit cycle is the cycle after both are held: bytes with w_strb[i] = 1 are written, holds clear, delay counter loads.
  - Delay 0 goes to W_RESP; otherwise W_WAIT.
  - Latency from the last of AW/W to b_valid = delay + 2 cycles.
  - W_RESP: b_valid holds until b_ready; then W_IDLE.
  - w_strb = 0 is a legal no-op write with OKAY response.
- Read/write collision: an AR handshake in the same cycle as a write commit to the same word returns the old data. A read sampled later sees the new data.
- Counter width is 4 bits.
- r_ready/b_ready held high need no special case: a response still lasts at least 1 cycle.

Decomposition:
- Package axil_mem_pkg:
  - RESP_OKAY = 2'b00, RESP_SLVERR = 2'b10.
  - Read and write state enums.
  - LFSR tap mask constant.
- Sub-module axil_lfsr16: clock, reset, seed parameter, 16-bit out; shared by both FSMs.
- Storage is an inferred byte-enabled register array inside the top module.

Test Plan:
- Fixed mode, FIX_DELAY=2: write 0xDEADBEEF to 0x10 with strb 4'hF, then read 0x10 with r_ready=1 → r_valid 3 cycles after the AR handshake, r_data 0xDEADBEEF, r_resp 0.
- Byte strobes: word 0x20 = 0x11223344, write 0xAABBCCDD with strb 4'b0101 → read returns 0x11BB33DD.
- W before AW: w_valid at cycle 0, aw_valid at cycle 3 → w_ready drops after capture, single commit, b_valid at cycle 5 with FIX_DELAY=0; b_ready held low 4 cycles → b_valid stays high and b_resp stays stable.
- Out of range: with DEPTH_LOG2=10, read 0x1000 → r_resp 2'b10, r_data 0; write to 0x1000 → b_resp 2'b10 and word 0 unchanged.
- Reset mid-operation: assert reset during R_WAIT → r_valid 0 immediately, no response after release, next read completes normally.
- Random mode, 1000 mixed transactions against a scoreboard → all data matches; every read latency between 1 and 8 cycles; no response is lost or duplicated.
